// File: rtl/sig_capture.sv
// sig_capture: trigger-armed waveform recorder.
// Watches an unsigned sample stream and waits for a rising crossing of
// trig_level (or a manual force_trig). It then records exactly 2**ADDR_WIDTH
// samples into an internal RAM, with the trigger sample at address 0.
// The record can be read back at any time through rd_addr/dout.
module sig_capture #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  arm,
  input  logic                  force_trig,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  armed,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   prev_q, prev_d;
  logic                    prev_valid_q, prev_valid_d;
  logic [DATA_WIDTH-1:0]   dout_q;

  // Record storage: one write port, one registered read port. Not reset.
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Trigger qualification. The level path needs a valid previous sample
  // below the threshold, so trig_level=0 can only be reached by force_trig.
  logic level_cross;
  logic trig_fire;

  assign level_cross = prev_valid_q && (prev_q < trig_level) && (din >= trig_level);
  assign trig_fire   = en && (force_trig || level_cross);

  // State register and datapath registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= ADDR_ZERO;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  // Next-state logic: abort beats arm, arm beats sample processing.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    if (arm) state_d = S_ARMED;
        S_ARMED:   if (trig_fire) state_d = S_CAPTURE;
        S_CAPTURE: if (en && (wr_addr_q == ADDR_LAST)) state_d = S_DONE;
        S_DONE:    if (arm) state_d = S_ARMED;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: write pointer, previous-sample tracker, RAM write.
  always_comb begin
    wr_addr_d    = wr_addr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr_q;
    mem_wdata    = din;
    if (abort) begin
      wr_addr_d    = ADDR_ZERO;
      prev_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          // Re-arming always starts a fresh record with no history.
          if (arm) begin
            wr_addr_d    = ADDR_ZERO;
            prev_valid_d = 1'b0;
          end
        end
        S_ARMED: begin
          if (trig_fire) begin
            // Trigger sample lands at address 0; capture continues at 1.
            mem_we    = 1'b1;
            mem_waddr = ADDR_ZERO;
            wr_addr_d = ADDR_ONE;
          end else if (en) begin
            prev_d       = din;
            prev_valid_d = 1'b1;
          end
        end
        S_CAPTURE: begin
          // Pointer wraps naturally to 0 after the last address.
          if (en) begin
            mem_we    = 1'b1;
            wr_addr_d = wr_addr_q + ADDR_ONE;
          end
        end
        default: begin
          wr_addr_d    = ADDR_ZERO;
          prev_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    armed = (state_q == S_ARMED);
    busy  = (state_q == S_CAPTURE);
    done  = (state_q == S_DONE);
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered readout every cycle; same-address write returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= '0;
    else     dout_q <= mem[rd_addr];
  end

  assign dout    = dout_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_sig_capture.sv
// Self-checking bench for sig_capture: directed scenarios plus a randomized
// run, all compared against a behavioural model of the recorder.
module tb_sig_capture;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] trig_level = '0;
  logic          arm = 1'b0;
  logic          force_trig = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] dout;
  logic [AW-1:0] wr_addr;
  logic          armed, busy, done;

  int n_vec = 0;
  int n_err = 0;

  sig_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .trig_level(trig_level),
    .arm(arm), .force_trig(force_trig), .abort(abort), .rd_addr(rd_addr),
    .dout(dout), .wr_addr(wr_addr), .armed(armed), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0=idle 1=armed 2=capture 3=done; mem -1 = unwritten.
  int m_mode, m_wa, m_prev, m_pv, m_dout;
  int m_mem [DEPTH];

  function automatic void model_reset();
    m_mode = 0; m_wa = 0; m_prev = 0; m_pv = 0; m_dout = 0;
  endfunction

  function automatic void model_clk();
    int rd;
    rd = m_mem[int'(rd_addr)];
    if (abort) begin
      m_mode = 0; m_wa = 0; m_pv = 0;
    end else if (m_mode == 0 || m_mode == 3) begin
      if (arm) begin m_mode = 1; m_wa = 0; m_pv = 0; end
    end else if (m_mode == 1) begin
      if (en) begin
        if (force_trig || (m_pv == 1 && m_prev < int'(trig_level) && int'(din) >= int'(trig_level))) begin
          m_mem[0] = int'(din); m_wa = 1; m_mode = 2;
        end else begin
          m_prev = int'(din); m_pv = 1;
        end
      end
    end else if (en) begin
      m_mem[m_wa] = int'(din);
      if (m_wa == DEPTH - 1) m_mode = 3;
      m_wa = (m_wa + 1) % DEPTH;
    end
    m_dout = rd;
  endfunction

  function automatic logic [AW+2:0] exp_stat();
    return {m_mode == 1, m_mode == 2, m_mode == 3, AW'(m_wa)};
  endfunction

  // Apply one cycle of inputs, clock it into DUT and model, settle.
  task automatic step(input logic e, input logic [DW-1:0] d, input logic a,
                      input logic f, input logic ab, input logic [AW-1:0] ra);
    en = e; din = d; arm = a; force_trig = f; abort = ab; rd_addr = ra;
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = -1;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({armed, busy, done, wr_addr, dout} !== '0)
      begin n_err++; $display("FAIL reset_state got %h want 0", {armed, busy, done, wr_addr, dout}); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_level_trigger();
    logic [DW-1:0] seq [4] = '{8'd10, 8'd50, 8'd100, 8'd130};
    trig_level = 8'd128;
    step(0, 0, 1, 0, 0, 0);
    n_vec++;
    if ({armed, busy, done, wr_addr} !== {3'b100, 8'd0})
      begin n_err++; $display("FAIL arm got %h want %h", {armed, busy, done, wr_addr}, {3'b100, 8'd0}); end
    for (int i = 0; i < 4; i++) begin
      step(1, seq[i], 0, 0, 0, 0);
      n_vec++;
      if ({armed, busy, done, wr_addr} !== ((i == 3) ? {3'b010, 8'd1} : {3'b100, 8'd0}))
        begin n_err++; $display("FAIL level_trig[%0d] got %h want %h", i, {armed, busy, done, wr_addr}, exp_stat()); end
    end
  endtask

  task automatic test_fill_readout();
    for (int i = 0; i < 255; i++) begin
      step(1, 8'(i), 0, 0, 0, 0);
      n_vec++;
      if ({armed, busy, done, wr_addr} !== exp_stat())
        begin n_err++; $display("FAIL fill[%0d] got %h want %h", i, {armed, busy, done, wr_addr}, exp_stat()); end
    end
    n_vec++;
    if ({armed, busy, done, wr_addr} !== {3'b001, 8'd0})
      begin n_err++; $display("FAIL fill_done got %h want %h", {armed, busy, done, wr_addr}, {3'b001, 8'd0}); end
    step(0, 0, 0, 0, 0, 8'd0);
    n_vec++;
    if (dout !== 8'd130) begin n_err++; $display("FAIL read0 got %0d want 130", dout); end
    step(0, 0, 0, 0, 0, 8'd1);
    n_vec++;
    if (dout !== 8'd0) begin n_err++; $display("FAIL read1 got %0d want 0", dout); end
    step(0, 0, 0, 0, 0, 8'd255);
    n_vec++;
    if (dout !== 8'd254) begin n_err++; $display("FAIL read255 got %0d want 254", dout); end
  endtask

  task automatic test_prev_rules();
    logic [DW-1:0] seq [4] = '{8'd200, 8'd200, 8'd50, 8'd128};
    trig_level = 8'd128;
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, seq[i], 0, 0, 0, 0);
      n_vec++;
      if ({armed, busy, done, wr_addr} !== ((i == 3) ? {3'b010, 8'd1} : {3'b100, 8'd0}))
        begin n_err++; $display("FAIL prev_rule[%0d] got %h want %h", i, {armed, busy, done, wr_addr}, exp_stat()); end
    end
    step(0, 0, 0, 0, 0, 8'd0);
    n_vec++;
    if (dout !== 8'd128) begin n_err++; $display("FAIL prev_rule_mem0 got %0d want 128", dout); end
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_force();
    step(0, 0, 1, 0, 0, 0);
    step(0, 8'd55, 0, 1, 0, 0);
    n_vec++;
    if ({armed, busy, done, wr_addr} !== {3'b100, 8'd0})
      begin n_err++; $display("FAIL force_no_en got %h want %h", {armed, busy, done, wr_addr}, {3'b100, 8'd0}); end
    step(1, 8'd7, 0, 1, 0, 0);
    n_vec++;
    if ({armed, busy, done, wr_addr} !== {3'b010, 8'd1})
      begin n_err++; $display("FAIL force_en got %h want %h", {armed, busy, done, wr_addr}, {3'b010, 8'd1}); end
    step(0, 0, 0, 0, 0, 8'd0);
    n_vec++;
    if (dout !== 8'd7) begin n_err++; $display("FAIL force_mem0 got %0d want 7", dout); end
  endtask

  task automatic test_abort_reset();
    for (int i = 0; i < 39; i++) step(1, 8'($urandom), 0, 0, 0, 0);
    n_vec++;
    if (wr_addr !== 8'd40) begin n_err++; $display("FAIL abort_pre got %0d want 40", wr_addr); end
    step(1, 8'd1, 1, 0, 1, 8'd0);
    n_vec++;
    if ({armed, busy, done, wr_addr} !== {3'b000, 8'd0})
      begin n_err++; $display("FAIL abort_wins got %h want 0", {armed, busy, done, wr_addr}); end
    step(0, 0, 0, 0, 0, 8'd0);
    n_vec++;
    if (dout !== 8'd7) begin n_err++; $display("FAIL abort_keeps_mem got %0d want 7", dout); end
    step(0, 0, 1, 0, 0, 0);
    step(1, 8'd9, 0, 1, 0, 0);
    for (int i = 0; i < 39; i++) step(1, 8'($urandom), 0, 0, 0, 8'd0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if ({armed, busy, done, wr_addr, dout} !== '0)
      begin n_err++; $display("FAIL async_reset got %h want 0", {armed, busy, done, wr_addr, dout}); end
    #1 rst = 1'b0;
    step(0, 0, 1, 0, 0, 0);
    step(1, 8'd3, 0, 1, 0, 0);
    n_vec++;
    if ({armed, busy, done, wr_addr} !== {3'b010, 8'd1})
      begin n_err++; $display("FAIL restart got %h want %h", {armed, busy, done, wr_addr}, {3'b010, 8'd1}); end
  endtask

  task automatic test_en_duty();
    int strobes = 1;
    int cyc = 0;
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 8'd77, 0, 1, 0, 0);
    while (strobes < DEPTH && cyc < 1000) begin
      logic e;
      e = (cyc % 3 == 0);
      step(e, 8'($urandom), 0, 1, 0, 8'($urandom));
      if (e) strobes++;
      cyc++;
      n_vec++;
      if ({armed, busy, done, wr_addr} !== {1'b0, strobes < DEPTH, strobes == DEPTH, AW'(strobes)})
        begin n_err++; $display("FAIL duty[%0d] got %h want %h", cyc, {armed, busy, done, wr_addr}, exp_stat()); end
    end
    n_vec++;
    if (strobes != DEPTH) begin n_err++; $display("FAIL duty_budget got %0d want %0d", strobes, DEPTH); end
    step(0, 0, 1, 0, 0, 0);
    n_vec++;
    if ({armed, busy, done, wr_addr} !== {3'b100, 8'd0})
      begin n_err++; $display("FAIL rearm_done got %h want %h", {armed, busy, done, wr_addr}, {3'b100, 8'd0}); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      if (c % 50 == 0) trig_level = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #3 rst = 1'b1;
        #1 model_reset();
        #1 rst = 1'b0;
      end
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0, 8'($urandom));
      n_vec++;
      if ({armed, busy, done, wr_addr} !== exp_stat())
        begin n_err++; $display("FAIL rand_stat[%0d] got %h want %h", c, {armed, busy, done, wr_addr}, exp_stat()); end
      if (m_dout >= 0) begin
        n_vec++;
        if (dout !== 8'(m_dout))
          begin n_err++; $display("FAIL rand_dout[%0d] got %0d want %0d", c, dout, m_dout); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_level_trigger();
    test_fill_readout();
    test_prev_rules();
    test_force();
    test_abort_reset();
    test_en_duty();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sig_capture.md
Name: sig_capture

Overview:
- Trigger-armed waveform recorder for the signal-generator path: it is the write-side counterpart to the ROM-readout sine generator.
- Watches an 8-bit sample stream (e.g. the generator's dout or a mic/ADC sample).
- Waits for a rising crossing of a programmable level, then writes a fixed-length record into an internal single-write/single-read RAM.
- The stored record can be read back at any time through an address port, e.g. for plotting against the generated waveform.

Parameters:
- ADDR_WIDTH, 8, record depth is 2**ADDR_WIDTH samples.
- DATA_WIDTH, 8, sample width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample strobe; din is valid only when en=1.
- din  input  DATA_WIDTH  incoming sample, unsigned.
- trig_level  input  DATA_WIDTH  trigger threshold, unsigned.
- arm  input  1  request to arm the trigger (level-sampled).
- force_trig  input  1  manual trigger, qualified by en.
- abort  input  1  cancel arm/capture and return to IDLE.
- rd_addr  input  ADDR_WIDTH  readout address.
- dout  output  DATA_WIDTH  readout data, registered.
- wr_addr  output  ADDR_WIDTH  current write pointer.
- armed  output  1  high in ARMED.
- busy  output  1  high in CAPTURE.
- done  output  1  high in DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE, wr_addr=0, prev sample=0, prev_valid=0, dout=0, armed=busy=done=0. RAM contents are not reset (undefined until written).
- States: IDLE, ARMED, CAPTURE, DONE. armed/busy/done are decoded directly from state registers, with no extra latency.
- Priority each cycle: abort > arm > sample processing.
- abort=1 in any state: next state IDLE, wr_addr=0, prev_valid=0. The RAM keeps whatever was written.
- IDLE: arm=1 -> ARMED, prev_valid=0, wr_addr=0.
- ARMED, en=1: trigger when force_trig=1, or when prev_valid=1 AND prev<trig_level AND din>=trig_level (unsigned compare).
  - On trigger: mem[0]<=din, wr_addr<=1, next state CAPTURE.
  - Otherwise: prev<=din, prev_valid<=1.
- ARMED, en=0: hold all state. A first sample can never trigger via level, because it needs a valid prev.
- ARMED, arm=1: no effect.
- CAPTURE, en=1: mem[wr_addr]<=din, wr_addr<=wr_addr+1 (mod 2**ADDR_WIDTH).
  - When the write is to address 2**ADDR_WIDTH-1, next state is DONE and wr_addr wraps to 0.
  - The record is therefore exactly 2**ADDR_WIDTH samples, with the trigger sample at address 0.
- CAPTURE, en=0: hold. arm and force_trig are ignored in CAPTURE.
- DONE: done=1, no writes.
  - arm=1 -> ARMED, prev_valid=0, wr_addr=0, done deasserts the next cycle.
- Readout:
  - dout<=mem[rd_addr] every cycle in every state; 1-cycle latency.
  - Same-address read and write in the same cycle returns the old contents (read-before-write).
- Width rules:
  - wr_addr wraps naturally.
  - Compares are unsigned, full DATA_WIDTH.
  - trig_level=0: the level condition can never fire (prev<0 is false), so only force_trig triggers.
- Reset mid-capture: immediate IDLE; a subsequent arm restarts from address 0.

Test Plan:
1. Reset then arm=1 for 1 cycle; en=1 with din=10,50,100,130 and trig_level=128 -> trigger on 130; mem[0]=130, busy=1, wr_addr=1.
2. Continue en=1 with din=0..254 (255 samples) -> done=1 after the 255th, wr_addr=0. Reading rd_addr=0,1,255 gives dout=130,0,254 one cycle after each address is applied.
3. Armed, first en=1 sample din=200 with trig_level=128 -> no trigger (prev invalid); next din=200 -> still no trigger (prev not below level); din=50 then din=128 -> trigger on 128.
4. Armed with force_trig=1 and en=0 -> no trigger; force_trig=1 and en=1 with din=7 -> CAPTURE, mem[0]=7.
5. Mid-capture at wr_addr=40, assert abort and arm together -> IDLE (abort wins), wr_addr=0. Repeat the scenario with rst=1 pulsed asynchronously -> all outputs 0 immediately.
6. In CAPTURE, toggle en with a 1-in-3 duty -> wr_addr advances only on en cycles, done after exactly 256 strobes. In DONE, arm=1 -> armed=1, done=0 the next cycle.
